// File: rtl/line_window_cache.sv
// line_window_cache: four-line ring of GBA pixel lines presenting a registered 3x3 RGB window
// Ports: pxlClk/rst (async, active-high); wrValid + wrRed/wrGreen/wrBlue write pixels;
// frameStart marks the start of a GBA frame; curPxl selects the window centre pixel;
// nextLine advances the display line; cacheUpdate refreshes sameLine;
// 27 window byte outputs {prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}Out;
// sameLine, newFrameOut flow-control flags; overrun sticky error (LINE_WINDOW_OVERRUN_EN).
module line_window_cache #(
    parameter int LINE_PIXELS = 240,
    parameter int FRAME_LINES = 160,
    parameter int PXL_IDX_W   = 8
) (
    input  logic                 pxlClk,
    input  logic                 rst,
    input  logic                 wrValid,
    input  logic [7:0]           wrRed,
    input  logic [7:0]           wrGreen,
    input  logic [7:0]           wrBlue,
    input  logic                 frameStart,
    input  logic [PXL_IDX_W-1:0] curPxl,
    input  logic                 nextLine,
    input  logic                 cacheUpdate,
    output logic [7:0]           prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
    output logic [7:0]           prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut,
    output logic [7:0]           prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
    output logic [7:0]           curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut,
    output logic [7:0]           curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut,
    output logic [7:0]           curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut,
    output logic [7:0]           nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
    output logic [7:0]           nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut,
    output logic [7:0]           nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut,
    output logic                 sameLine,
    output logic                 newFrameOut,
    output logic                 overrun
);
    localparam int LW = $clog2(FRAME_LINES) + 1;
    localparam logic [PXL_IDX_W-1:0] LAST_PX = PXL_IDX_W'(LINE_PIXELS - 1);
    localparam logic [LW-1:0] LAST_LN = LW'(FRAME_LINES - 1);

    logic [23:0]          mem [4][LINE_PIXELS];
    logic [23:0]          win [3][3];
    logic [PXL_IDX_W-1:0] wr_px, wr_addr, cp;
    logic [PXL_IDX_W-1:0] psel [3];
    logic [1:0]           bsel [3];
    logic [LW-1:0]        wr_line, lines_done, lines_done_nxt, rd_line;
    logic [1:0]           wr_buf, base_buf, rd_buf;
    logic                 armed, wr_en, line_end;

    // a frameStart write is always accepted and lands on pixel 0 of line 0
    assign wr_en          = wrValid && (frameStart || wr_line != LW'(FRAME_LINES));
    assign wr_addr        = frameStart ? '0 : wr_px;
    assign line_end       = wr_en && !frameStart && wr_px == LAST_PX;
    assign lines_done_nxt = frameStart ? '0 : lines_done + LW'(line_end);

    always_comb begin
        cp      = (curPxl > LAST_PX) ? LAST_PX : curPxl;
        psel[0] = (cp == '0) ? cp : cp - PXL_IDX_W'(1);
        psel[1] = cp;
        psel[2] = (cp == LAST_PX) ? cp : cp + PXL_IDX_W'(1);
        bsel[0] = (rd_line == '0) ? rd_buf : rd_buf - 2'd1;
        bsel[1] = rd_buf;
        bsel[2] = (rd_line == LAST_LN) ? rd_buf : rd_buf + 2'd1;
    end

    always_ff @(posedge pxlClk) begin
        if (wr_en) mem[wr_buf][wr_addr] <= {wrRed, wrGreen, wrBlue};
    end

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            wr_px       <= '0;
            wr_line     <= '0;
            wr_buf      <= '0;
            base_buf    <= '0;
            rd_line     <= '0;
            rd_buf      <= '0;
            lines_done  <= '0;
            armed       <= 1'b0;
            newFrameOut <= 1'b0;
            sameLine    <= 1'b0;
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 3; p++)
                    win[l][p] <= '0;
        end else begin
            lines_done <= lines_done_nxt;
            if (frameStart) begin
                wr_px    <= PXL_IDX_W'(wrValid);
                wr_line  <= '0;
                base_buf <= wr_buf;
            end else if (line_end) begin
                wr_px   <= '0;
                wr_line <= wr_line + LW'(1);
                wr_buf  <= wr_buf + 2'd1;
            end else if (wr_en) begin
                wr_px <= wr_px + PXL_IDX_W'(1);
            end
            // armed remembers a frameStart until its first two lines are complete
            if (armed && lines_done == LW'(2)) begin
                armed       <= 1'b0;
                newFrameOut <= 1'b1;
                rd_line     <= '0;
                rd_buf      <= base_buf;
            end else if (nextLine && newFrameOut) begin
                newFrameOut <= 1'b0;
            end else if (nextLine && rd_line != LAST_LN) begin
                rd_line <= rd_line + LW'(1);
                rd_buf  <= rd_buf + 2'd1;
            end
            if (frameStart) armed <= 1'b1;
            if (cacheUpdate)
                sameLine <= (rd_line + LW'(2) > lines_done_nxt) && (rd_line + LW'(1) < LAST_LN);
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 3; p++)
                    win[l][p] <= mem[bsel[l]][psel[p]];
        end
    end

`ifdef LINE_WINDOW_OVERRUN_EN
    // the writer is about to fill the buffer still needed as the prev line
    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (frameStart)
            overrun <= 1'b0;
        else if (line_end && rd_line != '0 && !newFrameOut && wr_buf + 2'd1 == rd_buf - 2'd1)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

    assign {prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut} = win[0][0];
    assign {prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut}  = win[0][1];
    assign {prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut} = win[0][2];
    assign {curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut}  = win[1][0];
    assign {curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut}   = win[1][1];
    assign {curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut}  = win[1][2];
    assign {nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut} = win[2][0];
    assign {nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut}  = win[2][1];
    assign {nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut} = win[2][2];
endmodule

// File: tb/tb_line_window_cache.sv
// tb_line_window_cache: directed/random bench for line_window_cache against a line-number model
module tb_line_window_cache;
    logic       pxlClk, rst, wrValid, frameStart, nextLine, cacheUpdate;
    logic [7:0] wrRed, wrGreen, wrBlue, curPxl;
    logic [7:0] prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut;
    logic [7:0] prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut;
    logic [7:0] prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut;
    logic [7:0] curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut;
    logic [7:0] curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut;
    logic [7:0] curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut;
    logic [7:0] nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut;
    logic [7:0] nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut;
    logic [7:0] nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut;
    logic       sameLine, newFrameOut, overrun;
    logic [23:0] got_w [3][3];

`ifdef LINE_WINDOW_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    // model: blue byte of each frame line (red = line number, green = pixel index)
    logic [7:0] blue [160][240];
    int  m_rd, m_done, m_wl;
    bit  m_nf, m_same, m_ovr;
    int  total, passed, fails;

    line_window_cache dut (
        .pxlClk(pxlClk), .rst(rst), .wrValid(wrValid),
        .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue),
        .frameStart(frameStart), .curPxl(curPxl), .nextLine(nextLine), .cacheUpdate(cacheUpdate),
        .prevLinePrevPxlRedOut(prevLinePrevPxlRedOut), .prevLinePrevPxlGreenOut(prevLinePrevPxlGreenOut), .prevLinePrevPxlBlueOut(prevLinePrevPxlBlueOut),
        .prevLineCurPxlRedOut(prevLineCurPxlRedOut), .prevLineCurPxlGreenOut(prevLineCurPxlGreenOut), .prevLineCurPxlBlueOut(prevLineCurPxlBlueOut),
        .prevLineNextPxlRedOut(prevLineNextPxlRedOut), .prevLineNextPxlGreenOut(prevLineNextPxlGreenOut), .prevLineNextPxlBlueOut(prevLineNextPxlBlueOut),
        .curLinePrevPxlRedOut(curLinePrevPxlRedOut), .curLinePrevPxlGreenOut(curLinePrevPxlGreenOut), .curLinePrevPxlBlueOut(curLinePrevPxlBlueOut),
        .curLineCurPxlRedOut(curLineCurPxlRedOut), .curLineCurPxlGreenOut(curLineCurPxlGreenOut), .curLineCurPxlBlueOut(curLineCurPxlBlueOut),
        .curLineNextPxlRedOut(curLineNextPxlRedOut), .curLineNextPxlGreenOut(curLineNextPxlGreenOut), .curLineNextPxlBlueOut(curLineNextPxlBlueOut),
        .nextLinePrevPxlRedOut(nextLinePrevPxlRedOut), .nextLinePrevPxlGreenOut(nextLinePrevPxlGreenOut), .nextLinePrevPxlBlueOut(nextLinePrevPxlBlueOut),
        .nextLineCurPxlRedOut(nextLineCurPxlRedOut), .nextLineCurPxlGreenOut(nextLineCurPxlGreenOut), .nextLineCurPxlBlueOut(nextLineCurPxlBlueOut),
        .nextLineNextPxlRedOut(nextLineNextPxlRedOut), .nextLineNextPxlGreenOut(nextLineNextPxlGreenOut), .nextLineNextPxlBlueOut(nextLineNextPxlBlueOut),
        .sameLine(sameLine), .newFrameOut(newFrameOut), .overrun(overrun)
    );

    assign got_w[0][0] = {prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut};
    assign got_w[0][1] = {prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut};
    assign got_w[0][2] = {prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut};
    assign got_w[1][0] = {curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut};
    assign got_w[1][1] = {curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut};
    assign got_w[1][2] = {curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut};
    assign got_w[2][0] = {nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut};
    assign got_w[2][1] = {nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut};
    assign got_w[2][2] = {nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut};

    initial pxlClk = 1'b0;
    always #5 pxlClk = ~pxlClk;

    task automatic tick();
        @(posedge pxlClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit same_f(input int rd, input int done);
        return (rd + 2 > done) && (rd + 1 < 159);
    endfunction

    task automatic check_win(input string tag);
        int lv [3];
        int pv [3];
        int c;
        c     = (curPxl > 239) ? 239 : int'(curPxl);
        lv[0] = (m_rd == 0) ? 0 : m_rd - 1;
        lv[1] = m_rd;
        lv[2] = (m_rd == 159) ? 159 : m_rd + 1;
        pv[0] = (c == 0) ? 0 : c - 1;
        pv[1] = c;
        pv[2] = (c == 239) ? 239 : c + 1;
        for (int l = 0; l < 3; l++)
            for (int p = 0; p < 3; p++)
                check($sformatf("%s[%0d][%0d]", tag, l, p), 32'(got_w[l][p]),
                      32'({8'(lv[l]), 8'(pv[p]), blue[lv[l]][pv[p]]}));
    endtask

    task automatic check_zero(input string tag);
        for (int l = 0; l < 3; l++)
            for (int p = 0; p < 3; p++)
                check($sformatf("%s_win[%0d][%0d]", tag, l, p), 32'(got_w[l][p]), 32'd0);
        check({tag, "_same"}, 32'(sameLine), 32'd0);
        check({tag, "_nf"}, 32'(newFrameOut), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    task automatic write_line(input int l, input bit fs, input bit cu);
        bit acc;
        if (fs) begin
            m_wl = 0;
            m_done = 0;
            m_ovr = 0;
        end
        acc = m_wl < 160;
        for (int n = 0; n < 240; n++) begin
            frameStart  = fs && n == 0;
            cacheUpdate = cu && n == 239;
            wrValid     = 1'b1;
            wrRed       = 8'(l);
            wrGreen     = 8'(n);
            wrBlue      = 8'($urandom);
            if (acc) blue[l][n] = wrBlue;
            tick();
        end
        wrValid = 1'b0;
        frameStart = 1'b0;
        cacheUpdate = 1'b0;
        if (cu) m_same = same_f(m_rd, acc ? m_done + 1 : m_done);
        if (acc) begin
            if (OVR_EN && m_rd > 0 && !m_nf && ((l + 2 - m_rd) & 3) == 0) m_ovr = 1'b1;
            m_done++;
            m_wl++;
        end
    endtask

    task automatic pulse_next();
        nextLine = 1'b1;
        tick();
        nextLine = 1'b0;
        if (m_nf) m_nf = 1'b0;
        else if (m_rd < 159) m_rd++;
    endtask

    task automatic cache_update();
        cacheUpdate = 1'b1;
        tick();
        cacheUpdate = 1'b0;
        m_same = same_f(m_rd, m_done);
    endtask

    initial begin
        int pxl_list [5];
        total = 0; passed = 0; fails = 0;
        m_rd = 0; m_done = 0; m_wl = 0; m_nf = 0; m_same = 0; m_ovr = 0;
        rst = 1'b1; wrValid = 1'b0; frameStart = 1'b0; nextLine = 1'b0; cacheUpdate = 1'b0;
        wrRed = '0; wrGreen = '0; wrBlue = '0; curPxl = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_zero("reset");

        // frame start coincident with pixel 0, then two complete lines
        write_line(0, 1'b1, 1'b0);
        write_line(1, 1'b0, 1'b0);
        check("nf_before", 32'(newFrameOut), 32'd0);
        curPxl = 8'd0;
        tick();
        m_nf = 1'b1;
        m_rd = 0;
        check("nf_set", 32'(newFrameOut), 32'd1);
        tick();
        check_win("win_f0");
        check("ovr_f0", 32'(overrun), 32'(m_ovr));

        // line advance: first pulse only clears newFrameOut
        write_line(2, 1'b0, 1'b0);
        pulse_next();
        check("nf_clr", 32'(newFrameOut), 32'(m_nf));
        tick();
        check_win("win_rd0");
        curPxl = 8'd100;
        pulse_next();
        tick();
        check_win("win_rd1");
        pxl_list = '{239, 240, 255, 1, int'($urandom_range(0, 255))};
        foreach (pxl_list[i]) begin
            curPxl = 8'(pxl_list[i]);
            tick();
            check_win($sformatf("win_px%0d", pxl_list[i]));
        end

        // sameLine around the read/write gap
        cache_update();
        check("same_rd1", 32'(sameLine), 32'(m_same));
        write_line(3, 1'b0, 1'b0);
        check("ovr_l3", 32'(overrun), 32'(m_ovr));
        cache_update();
        check("same_l3", 32'(sameLine), 32'(m_same));
        pulse_next();
        tick();
        check_win("win_rd2");
        nextLine = 1'b1;
        cacheUpdate = 1'b1;
        tick();
        nextLine = 1'b0;
        cacheUpdate = 1'b0;
        m_same = same_f(m_rd, m_done);
        m_rd++;
        check("same_simul_next", 32'(sameLine), 32'(m_same));
        cache_update();
        check("same_rd3", 32'(sameLine), 32'(m_same));
        write_line(4, 1'b0, 1'b1);
        check("same_simul_wr", 32'(sameLine), 32'(m_same));
        check("ovr_l4", 32'(overrun), 32'(m_ovr));
        tick();
        check_win("win_rd3");

        // rest of the frame, then one more line that must be ignored
        for (int l = 5; l < 160; l++) write_line(l, 1'b0, 1'b0);
        check("ovr_full", 32'(overrun), 32'(m_ovr));
        curPxl = 8'($urandom_range(0, 239));
        while (m_rd < 157) pulse_next();
        tick();
        check_win("win_rd157");
        write_line(160, 1'b0, 1'b0);
        tick();
        check_win("win_ignored_wr");
        cache_update();
        check("same_rd157", 32'(sameLine), 32'(m_same));

        // last line clamps
        while (m_rd < 159) pulse_next();
        curPxl = 8'd239;
        tick();
        check_win("win_last");
        pulse_next();
        tick();
        check_win("win_last_hold");
        curPxl = 8'd250;
        tick();
        check_win("win_last_over");
        cache_update();
        check("same_last", 32'(sameLine), 32'(m_same));
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        m_wl = 0;
        m_done = 0;
        m_ovr = 0;
        check("ovr_fs_clr", 32'(overrun), 32'(m_ovr));
        check("nf_fs_idle", 32'(newFrameOut), 32'(m_nf));

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check_zero("rst_async");
        tick();
        rst = 1'b0;
        m_rd = 0; m_done = 0; m_wl = 0; m_nf = 0; m_same = 0; m_ovr = 0;

        // lines without a frameStart never raise newFrameOut
        curPxl = 8'd7;
        write_line(0, 1'b0, 1'b0);
        write_line(1, 1'b0, 1'b0);
        repeat (2) tick();
        check("nf_noframe", 32'(newFrameOut), 32'd0);
        check_win("win_noframe");

        // new frame based on a non-zero buffer
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        m_wl = 0;
        m_done = 0;
        m_ovr = 0;
        write_line(0, 1'b0, 1'b0);
        write_line(1, 1'b0, 1'b0);
        tick();
        m_nf = 1'b1;
        m_rd = 0;
        check("nf_rebase", 32'(newFrameOut), 32'd1);
        curPxl = 8'($urandom_range(0, 255));
        tick();
        check_win("win_rebase");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
